// File: rtl/led_pkg.sv
// led_pkg: shared LED types, register map and helpers for the Wishbone LED bank.
package led_pkg;
    typedef struct packed {
        logic red;
        logic green;
        logic blue;
    } rgb_led_t;

    localparam logic [2:0] ADR_CTRL       = 3'd0;
    localparam logic [2:0] ADR_GREEN_ON   = 3'd1;
    localparam logic [2:0] ADR_RGB_ON     = 3'd2;
    localparam logic [2:0] ADR_DUTY       = 3'd3;
    localparam logic [2:0] ADR_BLINK_HALF = 3'd4;
    localparam logic [2:0] ADR_BLINK_MASK = 3'd5;

    localparam int CTRL_ENABLE   = 0;
    localparam int CTRL_BLINK_EN = 1;

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction
endpackage

// File: rtl/wb_led_bank_if.sv
// wb_led_bank_if: classic single-cycle-ack Wishbone bus between host and LED bank.
interface wb_led_bank_if;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [2:0]  adr_i;
    logic [3:0]  sel_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        err_o;
    logic        stall_o;

    modport master(output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
                   input dat_o, ack_o, err_o, stall_o);
    modport slave(input cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
                  output dat_o, ack_o, err_o, stall_o);
endinterface

// File: rtl/led_pwm_timer.sv
// led_pwm_timer: free-running PWM comparator plus blink half-period phase generator.
module led_pwm_timer #(
    parameter int PWM_BITS   = 8,
    parameter int BLINK_BITS = 24
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [PWM_BITS-1:0]   duty,
    input  logic [BLINK_BITS-1:0] blink_half,
    input  logic                  blink_restart,
    output logic                  pwm_on,
    output logic                  phase
);
    logic [PWM_BITS-1:0]   cnt;
    logic [BLINK_BITS-1:0] bcnt;

    // all-ones duty is fully on rather than one count short
    assign pwm_on = (&duty) | (cnt < duty);

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            cnt   <= '0;
            bcnt  <= '0;
            phase <= 1'b1;
        end else begin
            cnt <= cnt + PWM_BITS'(1);
            if (blink_restart || blink_half == '0) begin
                bcnt  <= '0;
                phase <= 1'b1;
            end else if (bcnt == blink_half - BLINK_BITS'(1)) begin
                bcnt  <= '0;
                phase <= ~phase;
            end else
                bcnt <= bcnt + BLINK_BITS'(1);
        end
endmodule

// File: rtl/wb_led_bank.sv
// wb_led_bank: Wishbone register bank driving green and RGB LEDs with
// global PWM brightness and per-LED blink masking.
module wb_led_bank
    import led_pkg::*;
#(
    parameter int NUM_GREEN  = 4,
    parameter int NUM_RGB    = 4,
    parameter int PWM_BITS   = 8,
    parameter int BLINK_BITS = 24
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    wb_led_bank_if.slave           bus,
    output logic [NUM_GREEN-1:0]   green_leds,
    output rgb_led_t [NUM_RGB-1:0] rgb_leds
);
    localparam int L = NUM_GREEN + 3 * NUM_RGB;

    logic [1:0]            ctrl;
    logic [NUM_GREEN-1:0]  green_on;
    logic [3*NUM_RGB-1:0]  rgb_on;
    logic [PWM_BITS-1:0]   duty;
    logic [BLINK_BITS-1:0] blink_half;
    logic [L-1:0]          blink_mask, leds, on, led_next;
    logic                  accept, mapped, wr, pwm_on, phase;
    logic [31:0]           wm, wd, rdata;

    assign accept       = bus.cyc_i & bus.stb_i & ~bus.ack_o & ~bus.err_o;
    assign mapped       = bus.adr_i <= ADR_BLINK_MASK;
    assign wr           = accept & mapped & bus.we_i;
    assign wm           = lane_mask(bus.sel_i);
    assign wd           = bus.dat_i & wm;
    assign bus.stall_o  = 1'b0;

    always_comb
        rdata = bus.adr_i == ADR_CTRL       ? 32'(ctrl) :
                bus.adr_i == ADR_GREEN_ON   ? 32'(green_on) :
                bus.adr_i == ADR_RGB_ON     ? 32'(rgb_on) :
                bus.adr_i == ADR_DUTY       ? 32'(duty) :
                bus.adr_i == ADR_BLINK_HALF ? 32'(blink_half) :
                bus.adr_i == ADR_BLINK_MASK ? 32'(blink_mask) : 32'h0;

    led_pwm_timer #(.PWM_BITS(PWM_BITS), .BLINK_BITS(BLINK_BITS)) u_timer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .duty         (duty),
        .blink_half   (blink_half),
        .blink_restart(wr && bus.adr_i == ADR_BLINK_HALF),
        .pwm_on       (pwm_on),
        .phase        (phase)
    );

    // green LEDs occupy the low bits, RGB LEDs follow in RGB_ON order
    assign on       = {rgb_on, green_on};
    assign led_next = {L{ctrl[CTRL_ENABLE] & pwm_on}} & on &
                      (~{L{ctrl[CTRL_BLINK_EN]}} | ~blink_mask | {L{phase}});

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            bus.ack_o  <= 1'b0;
            bus.err_o  <= 1'b0;
            bus.dat_o  <= '0;
            ctrl       <= '0;
            green_on   <= '0;
            rgb_on     <= '0;
            duty       <= '0;
            blink_half <= '0;
            blink_mask <= '0;
            leds       <= '0;
        end else begin
            bus.ack_o <= accept & mapped;
            bus.err_o <= accept & ~mapped;
            bus.dat_o <= (accept & mapped & ~bus.we_i) ? rdata : '0;
            leds      <= led_next;
            if (wr && bus.adr_i == ADR_CTRL)
                ctrl <= (ctrl & ~wm[1:0]) | wd[1:0];
            if (wr && bus.adr_i == ADR_GREEN_ON)
                green_on <= (green_on & ~wm[NUM_GREEN-1:0]) | wd[NUM_GREEN-1:0];
            if (wr && bus.adr_i == ADR_RGB_ON)
                rgb_on <= (rgb_on & ~wm[3*NUM_RGB-1:0]) | wd[3*NUM_RGB-1:0];
            if (wr && bus.adr_i == ADR_DUTY)
                duty <= (duty & ~wm[PWM_BITS-1:0]) | wd[PWM_BITS-1:0];
            if (wr && bus.adr_i == ADR_BLINK_HALF)
                blink_half <= (blink_half & ~wm[BLINK_BITS-1:0]) | wd[BLINK_BITS-1:0];
            if (wr && bus.adr_i == ADR_BLINK_MASK)
                blink_mask <= (blink_mask & ~wm[L-1:0]) | wd[L-1:0];
        end

    assign green_leds = leds[NUM_GREEN-1:0];
    assign rgb_leds   = leds[L-1:NUM_GREEN];
endmodule
